mux_2to1: RTL and testbench
===========================

// Module: mux_2to1
// PURPOSE
//  - Two-input selector: out follows in0 when sel=0 and in1 when sel=1, combinationally.
//  - Also provides a registered copy of the result and a select-activity monitor.
//  - Leaf datapath cell used wherever a 1-of-2 choice is needed.
//  - Pure-combinational users connect only sel/in0/in1/out.
// PARAMETERS
//  - WIDTH      1    data width of in0, in1, out, out_q
//  - CNT_WIDTH  16   width of switch_cnt
// PORTS
//  - clk         in   1          system clock, rising edge
//  - rst         in   1          reset, asynchronous, active-high
//  - sel         in   1          select: 0 -> in0, 1 -> in1
//  - in0         in   WIDTH      data input 0
//  - in1         in   WIDTH      data input 1
//  - out         out  WIDTH      combinational mux result
//  - out_q       out  WIDTH      registered mux result
//  - sel_q       out  1          registered sel
//  - switch_cnt  out  CNT_WIDTH  count of sel transitions (optional feature)
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-high.
//  - out = sel ? in1 : in0.
//    - Zero latency, no clock dependency.
//    - Valid while rst is asserted and with clk stopped.
//  - Truth table ({sel,in1,in0} -> out), WIDTH=1:
//    - 000->0, 001->1, 010->0, 011->1
//    - 100->0, 101->0, 110->1, 111->1
//  - X/Z on sel: out is X in simulation. No X-pessimism masking.
//  - out_q:
//    - Loads (sel ? in1 : in0) on every rising clk edge.
//    - 1-cycle latency relative to out.
//    - Reset value 0.
//  - sel_q:
//    - Loads sel on every rising clk edge.
//    - Reset value 0.
//  - Reset: asserting rst at any time clears out_q, sel_q and switch_cnt immediately. Release is synchronised by the user.
// CONFIGURATION
//  - Macro MUX_2TO1_SWITCH_CNT_EN.
//  - Defined:
//    - switch_cnt increments on each rising edge where sel != sel_q, i.e. one count per select change.
//    - Saturates at all-ones; no wrap-around.
//    - Reset value 0.
//  - Undefined:
//    - switch_cnt is tied to 0 and the counter logic is absent.
//    - Port list is unchanged.
// STRUCTURE
//  - Shared package mux_pkg holds:
//    - MUX_SEL_IN0 = 1'b0, MUX_SEL_IN1 = 1'b1
//    - default WIDTH and CNT_WIDTH constants
//  - One natural sub-module: mux_2to1_sat_cnt (saturating up-counter with async active-high reset).
//    - Instantiated only under MUX_2TO1_SWITCH_CNT_EN.
//  - Everything else lives in the top module.
// TESTING
//  - Exhaustive sweep: {sel,in1,in0} = 0..7, 100 ns each, no clk.
//    -> out matches the truth table for all 8 codes.
//  - Registered path: sel=1, in1=1, in0=0, one clk edge.
//    -> out_q=1, sel_q=1.
//    -> out_q lags out by exactly 1 cycle when in1 is toggled.
//  - Async reset: rst=1 mid-cycle with out_q=1.
//    -> out_q=0, sel_q=0 and switch_cnt=0 immediately, with no clk edge.
//    -> out still equals the mux result while rst is asserted.
//  - Counter (macro defined): toggle sel 5 times across 10 clk edges.
//    -> switch_cnt=5.
//    -> With CNT_WIDTH=2 the same toggling gives switch_cnt=3 (saturated).
//  - Counter (macro undefined): any sel activity -> switch_cnt stays 0.
//  - WIDTH=8: in0=8'hA5, in1=8'h3C, sel=0 -> out=8'hA5; sel=1 -> out=8'h3C.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants for the 2:1 selector cell: select encodings and default widths.
package mux_pkg;

  localparam logic MUX_SEL_IN0 = 1'b0;
  localparam logic MUX_SEL_IN1 = 1'b1;

  localparam int MUX_DEF_WIDTH     = 1;
  localparam int MUX_DEF_CNT_WIDTH = 16;

endpackage

// File: rtl/mux_2to1_sat_cnt.sv
// Saturating up-counter with asynchronous active-high reset.
module mux_2to1_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Hold at all-ones instead of wrapping so a busy select never reads as idle.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mux_2to1.sv
// 2:1 selector with registered result, registered select and optional select-change
// counter (enable with macro MUX_2TO1_SWITCH_CNT_EN; otherwise switch_cnt is tied to 0).
module mux_2to1
  import mux_pkg::*;
#(
  parameter int WIDTH     = MUX_DEF_WIDTH,
  parameter int CNT_WIDTH = MUX_DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sel,
  input  logic [WIDTH-1:0]     in0,
  input  logic [WIDTH-1:0]     in1,
  output logic [WIDTH-1:0]     out,
  output logic [WIDTH-1:0]     out_q,
  output logic                 sel_q,
  output logic [CNT_WIDTH-1:0] switch_cnt
);

  logic [WIDTH-1:0] out_d;
  logic             sel_d;
  logic [WIDTH-1:0] out_r;
  logic             sel_r;

  // An unknown select propagates as X rather than silently picking a leg.
  always_comb begin
    out_d = in0;
    sel_d = sel;
    case (sel)
      MUX_SEL_IN0: out_d = in0;
      MUX_SEL_IN1: out_d = in1;
      default:     out_d = {WIDTH{1'bx}};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r <= {WIDTH{1'b0}};
      sel_r <= 1'b0;
    end else begin
      out_r <= out_d;
      sel_r <= sel_d;
    end
  end

  assign out   = out_d;
  assign out_q = out_r;
  assign sel_q = sel_r;

`ifdef MUX_2TO1_SWITCH_CNT_EN
  logic sel_change_s;

  assign sel_change_s = (sel != sel_r);

  mux_2to1_sat_cnt #(
    .W (CNT_WIDTH)
  ) u_sat_cnt (
    .clk (clk),
    .rst (rst),
    .inc (sel_change_s),
    .cnt (switch_cnt)
  );
`else
  assign switch_cnt = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_mux_2to1.sv
// Self-checking bench for mux_2to1: a WIDTH=1/CNT_WIDTH=16 instance and a WIDTH=8/CNT_WIDTH=2 instance.
module tb_mux_2to1;

  logic       clk    = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst    = 1'b1;
  logic       sel    = 1'b0;
  logic       in0    = 1'b0;
  logic       in1    = 1'b0;
  logic [7:0] w0     = 8'h00;
  logic [7:0] w1     = 8'h00;

  logic        out, out_q, sel_q;
  logic [15:0] cnt16;
  logic [7:0]  out8, out8_q;
  logic        sel8_q;
  logic [1:0]  cnt2;

  mux_2to1 #(.WIDTH(1), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .sel(sel), .in0(in0), .in1(in1),
    .out(out), .out_q(out_q), .sel_q(sel_q), .switch_cnt(cnt16)
  );

  mux_2to1 #(.WIDTH(8), .CNT_WIDTH(2)) u_dut8 (
    .clk(clk), .rst(rst), .sel(sel), .in0(w0), .in1(w1),
    .out(out8), .out_q(out8_q), .sel_q(sel8_q), .switch_cnt(cnt2)
  );

  // Clock runs only when enabled so the combinational sweep sees no edges.
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  int passed = 0;
  int total  = 0;

  // Truth table indexed by {sel,in1,in0}.
  logic [7:0] tt;

  // Reference model state
  logic       m_out_q;
  logic [7:0] m_out8_q;
  logic       m_sel_q;
  int         m_cnt16;
  int         m_cnt2;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_out_q  = 1'b0;
    m_out8_q = 8'h00;
    m_sel_q  = 1'b0;
    m_cnt16  = 0;
    m_cnt2   = 0;
  endtask

  task automatic chk_comb();
    chk("out", {15'd0, out}, {15'd0, tt[{sel, in1, in0}]});
    chk("out8", {8'd0, out8}, {8'd0, (sel ? w1 : w0)});
  endtask

  task automatic chk_regs();
    chk("out_q", {15'd0, out_q}, {15'd0, m_out_q});
    chk("out8_q", {8'd0, out8_q}, {8'd0, m_out8_q});
    chk("sel_q", {15'd0, sel_q}, {15'd0, m_sel_q});
    chk("sel8_q", {15'd0, sel8_q}, {15'd0, m_sel_q});
    chk("cnt16", cnt16, 16'(m_cnt16));
    chk("cnt2", {14'd0, cnt2}, 16'(m_cnt2));
  endtask

  // One rising edge: predict from the current inputs, then compare just after the edge.
  task automatic tick();
    logic       n_out_q;
    logic [7:0] n_out8_q;
    n_out_q  = tt[{sel, in1, in0}];
    n_out8_q = sel ? w1 : w0;
`ifdef MUX_2TO1_SWITCH_CNT_EN
    if (sel != m_sel_q) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt2 < 3) m_cnt2++;
    end
`endif
    @(posedge clk);
    #1;
    m_out_q  = n_out_q;
    m_out8_q = n_out8_q;
    m_sel_q  = sel;
    chk_regs();
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] code;
    tt = 8'hCA;
    model_reset();

    // Reset state with rst held and no clock
    #1;
    chk_regs();

    // Exhaustive combinational sweep, clock stopped
    for (int i = 0; i < 8; i++) begin
      code = 3'(i);
      {sel, in1, in0} = code;
      #100;
      chk("sweep", {15'd0, out}, {15'd0, tt[code]});
      chk("sweep_out_q", {15'd0, out_q}, 16'd0);
    end

    #10;
    rst    = 1'b0;
    clk_en = 1'b1;
    @(negedge clk);

    // Registered path and 1-cycle lag
    sel = 1'b1; in1 = 1'b1; in0 = 1'b0; w0 = 8'hA5; w1 = 8'h3C;
    #1;
    chk_comb();
    chk("out8_sel1", {8'd0, out8}, 16'h003C);
    tick();
    chk("reg_out_q", {15'd0, out_q}, 16'd1);
    chk("reg_sel_q", {15'd0, sel_q}, 16'd1);
    in1 = 1'b0;
    #1;
    chk("lag_out", {15'd0, out}, 16'd0);
    chk("lag_out_q", {15'd0, out_q}, 16'd1);
    tick();

    sel = 1'b0;
    #1;
    chk("out8_sel0", {8'd0, out8}, 16'h00A5);
    tick();

    // Asynchronous reset mid-cycle with out_q=1
    sel = 1'b1; in1 = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_out_q", {15'd0, out_q}, 16'd0);
    chk("async_sel_q", {15'd0, sel_q}, 16'd0);
    chk("async_cnt", cnt16, 16'd0);
    chk("async_out", {15'd0, out}, 16'd1);
    chk_regs();
    @(negedge clk);
    rst = 1'b0;
    sel = 1'b0;

    // Five select changes across ten edges
    for (int i = 0; i < 10; i++) begin
      sel = ((i % 4) < 2) ? 1'b1 : 1'b0;
      tick();
    end
`ifdef MUX_2TO1_SWITCH_CNT_EN
    chk("cnt_five", cnt16, 16'd5);
    chk("cnt_sat", {14'd0, cnt2}, 16'd3);
`else
    chk("cnt_off", cnt16, 16'd0);
    chk("cnt2_off", {14'd0, cnt2}, 16'd0);
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 40; i++) begin
      sel = 1'($urandom_range(0, 1));
      in0 = 1'($urandom_range(0, 1));
      in1 = 1'($urandom_range(0, 1));
      w0  = 8'($urandom_range(0, 255));
      w1  = 8'($urandom_range(0, 255));
      #1;
      chk_comb();
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
